// File: rtl/square_plotter_if.sv
// Request/pixel bus between a square source and square_plotter.
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_x/req_y/req_colour : top-left corner and RGB colour of the square
//   plot, vga_x, vga_y, vga_colour : per-cycle VGA pixel write
//   busy : plotter is drawing or finishing; done : one-cycle completion pulse
interface square_plotter_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_colour;
    logic       plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_x, req_y, req_colour,
        input  req_ready, plot, vga_x, vga_y, vga_colour, busy, done
    );

    modport slave (
        input  req_valid, req_x, req_y, req_colour,
        output req_ready, plot, vga_x, vga_y, vga_colour, busy, done
    );
endinterface

// File: rtl/square_plotter.sv
// Draws a SIZE x SIZE filled square, one pixel per cycle in raster order, with screen clipping.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : square_plotter_if.slave (request handshake in, VGA pixel stream and status out)
module square_plotter #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned X_MAX = 160,
    parameter int unsigned Y_MAX = 120
) (
    input logic              clk,
    input logic              reset,
    square_plotter_if.slave  bus
);

    if (SIZE < 1 || SIZE > 8) begin : g_bad_size
        $error("square_plotter: SIZE must be in 1..8");
    end

    localparam logic [2:0] LAST = 3'(SIZE - 1);

    typedef enum logic [1:0] {StIdle, StDraw, StDone} state_t;

    state_t     state_q, state_d;
    logic [2:0] cx_q, cx_d;
    logic [2:0] cy_q, cy_d;
    logic [7:0] base_x_q, base_x_d;
    logic [6:0] base_y_q, base_y_d;
    logic [2:0] colour_q, colour_d;

    logic       req_ready;
    logic       plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cx_q     <= '0;
            cy_q     <= '0;
            base_x_q <= '0;
            base_y_q <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            colour_q <= colour_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        base_x_d   = base_x_q;
        base_y_d   = base_y_q;
        colour_d   = colour_q;
        req_ready  = 1'b0;
        plot       = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Ready drops combinationally with reset so nothing is accepted while it is held.
                req_ready = !reset;
                if (bus.req_valid) begin
                    base_x_d = bus.req_x;
                    base_y_d = bus.req_y;
                    colour_d = bus.req_colour;
                    cx_d     = '0;
                    cy_d     = '0;
                    state_d  = StDraw;
                end
            end

            StDraw: begin
                // Coordinates wrap at the port widths; wrapped pixels are then clipped or not.
                vga_x      = base_x_q + {5'b0, cx_q};
                vga_y      = base_y_q + {4'b0, cy_q};
                vga_colour = colour_q;
                plot       = (32'(vga_x) < X_MAX) && (32'(vga_y) < Y_MAX);
                if (cx_q == LAST) begin
                    cx_d = '0;
                    if (cy_q == LAST) begin
                        state_d = StDone;
                    end else begin
                        cy_d = 3'(cy_q + 3'd1);
                    end
                end else begin
                    cx_d = 3'(cx_q + 3'd1);
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    assign bus.req_ready  = req_ready;
    assign bus.plot       = plot;
    assign bus.vga_x      = vga_x;
    assign bus.vga_y      = vga_y;
    assign bus.vga_colour = vga_colour;
    assign bus.done       = done;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_square_plotter.sv
module tb_square_plotter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    square_plotter_if bus ();
    square_plotter_if bus1 ();

    square_plotter #(.SIZE(4), .X_MAX(160), .Y_MAX(120)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    square_plotter #(.SIZE(1), .X_MAX(160), .Y_MAX(120)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Expected plotted pixels, packed {x, y, colour}, in output order.
    logic [17:0] exp_q[$];
    logic [17:0] px_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model for a 4x4 square: pushes the first max_pix scan positions that survive
    // clipping, returns how many were pushed.
    function automatic int push_square(input int x, input int y, input int c, input int max_pix);
        int n = 0;
        int pushed = 0;
        for (int cy = 0; cy < 4; cy++) begin
            for (int cx = 0; cx < 4; cx++) begin
                int px;
                int py;
                n++;
                if (n > max_pix) return pushed;
                px = (x + cx) % 256;
                py = (y + cy) % 128;
                if (px < 160 && py < 120) begin
                    exp_q.push_back({8'(px), 7'(py), 3'(c)});
                    pushed++;
                end
            end
        end
        return pushed;
    endfunction

    // Pixel scoreboard and idle-output monitor for the SIZE=4 plotter.
    always @(negedge clk) begin
        if (bus.plot) begin
            if (exp_q.size() > 0) px_exp = exp_q.pop_front();
            else px_exp = '1;
            check("pixel", {14'b0, bus.vga_x, bus.vga_y, bus.vga_colour}, {14'b0, px_exp});
        end
        if (!bus.busy) begin
            check("idle_outputs", {13'b0, bus.plot, bus.vga_x, bus.vga_y, bus.vga_colour}, 32'd0);
        end
    end

    // Called right after the accepting edge; walks the 18-cycle request period.
    task automatic watch_square(input bit hold, input bit scramble, input int exp_plots);
        int plots = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (!hold) bus.req_valid = 1'b0;
            if (scramble && k < 18) begin
                bus.req_x      = 8'($urandom);
                bus.req_y      = 7'($urandom);
                bus.req_colour = 3'($urandom);
            end
            if (k <= 16) begin
                if (bus.plot) plots++;
                check("busy_draw", {31'b0, bus.busy}, 32'd1);
                check("ready_draw", {31'b0, bus.req_ready}, 32'd0);
                check("done_draw", {31'b0, bus.done}, 32'd0);
            end else if (k == 17) begin
                check("done_pulse", {31'b0, bus.done}, 32'd1);
                check("plot_in_done", {31'b0, bus.plot}, 32'd0);
                check("ready_in_done", {31'b0, bus.req_ready}, 32'd0);
                check("busy_in_done", {31'b0, bus.busy}, 32'd1);
            end else begin
                check("ready_back", {31'b0, bus.req_ready}, 32'd1);
                check("busy_idle", {31'b0, bus.busy}, 32'd0);
                check("done_idle", {31'b0, bus.done}, 32'd0);
            end
        end
        check("plot_count", 32'(plots), 32'(exp_plots));
    endtask

    task automatic set_req(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        bus.req_valid  = 1'b1;
        bus.req_x      = x;
        bus.req_y      = y;
        bus.req_colour = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n1;
        int n2;
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_x       = '0;
        bus.req_y       = '0;
        bus.req_colour  = '0;
        bus1.req_valid  = 1'b0;
        bus1.req_x      = '0;
        bus1.req_y      = '0;
        bus1.req_colour = '0;

        repeat (3) @(negedge clk);
        check("ready_in_reset", {31'b0, bus.req_ready}, 32'd0);
        check("busy_in_reset", {31'b0, bus.busy}, 32'd0);
        check("done_in_reset", {31'b0, bus.done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

        // Basic square.
        set_req(8'd1, 7'd53, 3'b100);
        n1 = push_square(1, 53, 4, 16);
        @(posedge clk);
        watch_square(1'b0, 1'b0, n1);

        // Back-to-back with req_valid held: second accepted exactly 18 cycles later.
        set_req(8'd6, 7'd64, 3'b110);
        n1 = push_square(6, 64, 6, 16);
        @(posedge clk);
        #1 bus.req_x = 8'd11;
        n2 = push_square(11, 64, 6, 16);
        watch_square(1'b1, 1'b0, n1);
        @(posedge clk);
        watch_square(1'b0, 1'b0, n2);

        // Right/bottom edge clipping.
        set_req(8'd158, 7'd118, 3'b011);
        n1 = push_square(158, 118, 3, 16);
        @(posedge clk);
        watch_square(1'b0, 1'b0, n1);

        // Coordinate wrap past 255/127, then clipping of the wrapped square.
        set_req(8'd254, 7'd126, 3'b101);
        n1 = push_square(254, 126, 5, 16);
        @(posedge clk);
        watch_square(1'b0, 1'b0, n1);

        // Request inputs churn during DRAW; pixels must use the accepted values.
        set_req(8'd40, 7'd10, 3'b101);
        n1 = push_square(40, 10, 5, 16);
        @(posedge clk);
        watch_square(1'b0, 1'b1, n1);

        // Reset during the 7th pixel aborts with no done pulse.
        set_req(8'd20, 7'd30, 3'b010);
        void'(push_square(20, 30, 2, 7));
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
        end
        check("plot_7th_pixel", {31'b0, bus.plot}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_plot", {31'b0, bus.plot}, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_ready_in_reset", {31'b0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", {31'b0, bus.req_ready}, 32'd1);
        check("abort_no_done", {31'b0, bus.done}, 32'd0);
        check("abort_queue_drained", 32'(exp_q.size()), 32'd0);

        // Clean square after the abort.
        set_req(8'd100, 7'd100, 3'b001);
        n1 = push_square(100, 100, 1, 16);
        @(posedge clk);
        watch_square(1'b0, 1'b0, n1);

        // SIZE=1 build: one pixel, then done.
        bus1.req_valid  = 1'b1;
        bus1.req_x      = 8'd0;
        bus1.req_y      = 7'd0;
        bus1.req_colour = 3'b111;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        check("s1_plot", {31'b0, bus1.plot}, 32'd1);
        check("s1_pixel", {14'b0, bus1.vga_x, bus1.vga_y, bus1.vga_colour}, {14'b0, 8'd0, 7'd0, 3'b111});
        check("s1_done_early", {31'b0, bus1.done}, 32'd0);
        @(negedge clk);
        check("s1_done", {31'b0, bus1.done}, 32'd1);
        check("s1_plot_in_done", {31'b0, bus1.plot}, 32'd0);
        @(negedge clk);
        check("s1_ready_back", {31'b0, bus1.req_ready}, 32'd1);
        check("s1_done_cleared", {31'b0, bus1.done}, 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/square_plotter.md
SQUARE_PLOTTER -- requirements
Module: square_plotter

Interface
REQ-001 Parameter: SIZE, default 4, square edge length in pixels; legal range 1..8.
REQ-002 Parameter: X_MAX, default 160, screen width; pixels with x >= X_MAX are clipped.
REQ-003 Parameter: Y_MAX, default 120, screen height; pixels with y >= Y_MAX are clipped.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: req_valid  input  1  square request present.
REQ-007 Port: req_ready  output  1  plotter can accept a request.
REQ-008 Port: req_x  input  8  square top-left x.
REQ-009 Port: req_y  input  7  square top-left y.
REQ-010 Port: req_colour  input  3  square colour, RGB one bit each (000 = black/erase).
REQ-011 Port: plot  output  1  VGA pixel write enable.
REQ-012 Port: vga_x  output  8  pixel x.
REQ-013 Port: vga_y  output  7  pixel y.
REQ-014 Port: vga_colour  output  3  pixel colour.
REQ-015 Port: busy  output  1  high in DRAW and DONE.
REQ-016 Port: done  output  1  one-cycle pulse on square completion.

Function
REQ-017 FSM states: IDLE, DRAW, DONE; reset state IDLE.
REQ-018 req_ready SHALL be 1 only in IDLE with reset low.
REQ-019 Accept when req_valid && req_ready: latch req_x, req_y, req_colour; zero column counter cx and row counter cy; go to DRAW.
REQ-020 In IDLE without req_valid: stay IDLE; plot=0, done=0.
REQ-021 DRAW, every cycle: vga_x = base_x + cx, vga_y = base_y + cy, vga_colour = latched colour.
REQ-022 Sum widths: x mod 256 (8 bits), y mod 128 (7 bits); no carry out.
REQ-023 plot=1 in DRAW only when vga_x < X_MAX and vga_y < Y_MAX; clipped pixels still consume their cycle.
REQ-024 Scan order: raster, cx fastest; cx==SIZE-1 -> cx=0, cy+=1.
REQ-025 cx==SIZE-1 and cy==SIZE-1 -> go to DONE after that pixel cycle.
REQ-026 DRAW lasts exactly SIZE*SIZE cycles; first pixel is in the cycle after acceptance.
REQ-027 DONE: done=1, plot=0, req_ready=0 for exactly one cycle; then IDLE.
REQ-028 Minimum request period: SIZE*SIZE+2 cycles (18 for SIZE=4).
REQ-029 Request inputs are ignored outside IDLE; a source holding req_valid is accepted in the first IDLE cycle.
REQ-030 Outside DRAW: plot=0; vga_x, vga_y, vga_colour = 0.
REQ-031 busy = (state != IDLE).

Reset
REQ-032 reset high at a clock edge: next state IDLE, cx=cy=0, latched request cleared; plot, done, busy, vga_x, vga_y, vga_colour = 0.
REQ-033 req_ready SHALL be 0 while reset is high and 1 in the first cycle after reset falls.
REQ-034 Reset mid-DRAW or in DONE: abort with no done pulse; the partial square is not resumed.

Verification
REQ-035 Reset; request (x=1, y=53, colour=100) -> 16 plot cycles covering x 1..4, y 53..56, x fastest, colour 100; done on the 17th cycle after accept; req_ready back to 1 on the 18th.
REQ-036 req_valid held with two queued requests (x=6, then x=11, y=64, colour=110) -> second accepted exactly 18 cycles after the first; req_ready=0 throughout DRAW/DONE.
REQ-037 Request (x=158, y=118, colour=011) -> 16 DRAW cycles, plot=1 only at (158,118), (159,118), (158,119), (159,119); done still at cycle 17.
REQ-038 reset asserted during the 7th pixel of a square -> next cycle plot=0, busy=0, no done pulse; following cycle req_ready=1.
REQ-039 req_x, req_y, req_colour changed every cycle during DRAW -> output pixels match the values latched at accept.
REQ-040 SIZE=1 build; request (x=0, y=0, colour=111) -> a single plot cycle at (0,0), then done on the next cycle.
